// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the PWM master and slave sides of the board bus.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b0101010;

  localparam int START_Q = 2;
  localparam int BIT_Q   = 4;
  localparam int STOP_Q  = 3;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1 and emits a one-cycle tick on the last count.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/i2c_pwm_master.sv
// Write-only I2C master: sends {addr, W} then one PWM duty byte, reports done and any NACK.
module i2c_pwm_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 250,
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] duty_in,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  state_t      state;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [15:0] shift;
  logic        nack;
  logic        tick;
  logic        accept;

  // The done cycle is still IDLE, so it is excluded explicitly to drop a start arriving with done.
  assign accept = start && (state == IDLE) && !done;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      shift     <= 16'd0;
      nack      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state     <= START;
        phase     <= 2'd0;
        shift     <= {SLAVE_ADDR, 1'b0, duty_in};
        busy      <= 1'b1;
        ack_error <= 1'b0;
        sda_oe    <= 1'b1;
        scl_oe    <= 1'b0;
      end else if (tick) begin
        phase <= phase + 2'd1;
        case (state)
          START: begin
            scl_oe <= 1'b1;
            if (phase == 2'(START_Q - 1)) begin
              state   <= ADDR;
              phase   <= 2'd0;
              bit_cnt <= 3'd7;
              sda_oe  <= ~shift[15];
            end
          end
          // Outputs for the next quarter are set on the tick that ends the current one.
          ADDR, DATA: begin
            if (phase == 2'd1) begin
              scl_oe <= 1'b0;
            end else if (phase == 2'(BIT_Q - 1)) begin
              scl_oe  <= 1'b1;
              shift   <= {shift[14:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                state  <= (state == ADDR) ? ACK1 : ACK2;
                sda_oe <= 1'b0;
              end else begin
                sda_oe <= ~shift[14];
              end
            end
          end
          ACK1, ACK2: begin
            if (phase == 2'd1) begin
              scl_oe <= 1'b0;
            end else if (phase == 2'd2) begin
              nack <= sda_in;
            end else if (phase == 2'(BIT_Q - 1)) begin
              scl_oe <= 1'b1;
              if (nack) ack_error <= 1'b1;
              if (state == ACK1 && !nack) begin
                state   <= DATA;
                bit_cnt <= 3'd7;
                sda_oe  <= ~shift[15];
              end else begin
                state  <= STOP;
                sda_oe <= 1'b1;
              end
            end
          end
          STOP: begin
            if (phase == 2'd0) begin
              scl_oe <= 1'b0;
            end else if (phase == 2'd1) begin
              sda_oe <= 1'b0;
            end else if (phase == 2'(STOP_Q - 1)) begin
              state <= IDLE;
              phase <= 2'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: phase <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_pwm_master.sv
// Directed bench for i2c_pwm_master with an I2C slave model, protocol monitor and scoreboard.
module tb_i2c_pwm_master;

  localparam int CLK_DIV = 4;
  localparam int FULL_Q  = 2 + 8 * 4 + 4 + 8 * 4 + 4 + 3;
  localparam int NACK_Q  = 2 + 8 * 4 + 4 + 3;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         check_data;
    int         edges;
    logic       ackerr;
    int         latency;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] duty_in = 8'h00;
  logic       busy, done, ack_error, sda_oe, scl_oe;
  logic       slave_pull = 1'b0;
  logic       scl, sda;

  assign scl = ~scl_oe;
  assign sda = ~(sda_oe | slave_pull);

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   exp_stops = 0;

  bit         ack_addr = 1'b1;
  bit         ack_data = 1'b1;
  bit         in_frame = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bit_idx = 0;
  logic [7:0] rx_addr = 8'h00;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] frame_addr = 8'h00;
  logic [7:0] frame_data = 8'h00;
  int         frame_edges = 0;
  int         stop_cnt = 0;
  int         violations = 0;

  i2c_pwm_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h2A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .duty_in   (duty_in),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error),
    .sda_in    (sda),
    .sda_oe    (sda_oe),
    .scl_oe    (scl_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave model and protocol monitor share one sampler on the falling clock edge.
  always @(negedge clk) begin
    if (scl && prev_scl && sda !== prev_sda) begin
      if (!sda) begin
        if (in_frame) violations++;
        in_frame = 1'b1;
        bit_idx  = 0;
        rx_addr  = 8'h00;
        rx_data  = 8'h00;
      end else begin
        if (!in_frame) violations++;
        stop_cnt++;
        frame_addr  = rx_addr;
        frame_data  = rx_data;
        frame_edges = bit_idx;
        in_frame    = 1'b0;
      end
      slave_pull = 1'b0;
    end else if (in_frame) begin
      if (scl && !prev_scl) begin
        bit_idx++;
        if (bit_idx <= 8) rx_addr = {rx_addr[6:0], sda};
        else if (bit_idx >= 10 && bit_idx <= 17) rx_data = {rx_data[6:0], sda};
      end else if (!scl && prev_scl) begin
        slave_pull = (bit_idx == 8 && ack_addr) || (bit_idx == 17 && ack_data);
      end
    end
    if (!busy) begin
      in_frame   = 1'b0;
      slave_pull = 1'b0;
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] d, input bit ack_a,
                               input bit ack_d, input bit push);
    exp_t e;
    ack_addr = ack_a;
    ack_data = ack_d;
    if (push) begin
      e.addr       = {7'h2A, 1'b0};
      e.data       = d;
      e.check_data = ack_a;
      e.edges      = ack_a ? 19 : 10;
      e.ackerr     = !(ack_a && ack_d);
      e.latency    = (ack_a ? FULL_Q : NACK_Q) * CLK_DIV;
      sb.push_back(e);
      exp_stops++;
    end
    @(negedge clk);
    start   = 1'b1;
    duty_in = d;
    @(negedge clk);
    start      = 1'b0;
    accept_cyc = cyc;
    check({tag, " busy_after_accept"}, busy, 1);
    check({tag, " ackerr_cleared"}, ack_error, 0);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   n;
    bit   seen;
    n    = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, seen, 1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, cyc - accept_cyc, e.latency);
      check({tag, " ack_error"}, ack_error, e.ackerr);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " rx_addr"}, frame_addr, e.addr);
      if (e.check_data) check({tag, " rx_data"}, frame_data, e.data);
      check({tag, " scl_edges"}, frame_edges, e.edges);
    end
    check({tag, " stop_count"}, stop_cnt, exp_stops);
    check({tag, " protocol"}, violations, 0);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    int extra_done;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ack_error", ack_error, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset scl_oe", scl_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus("full_a5", 8'hA5, 1'b1, 1'b1, 1'b1);
    checkOutput("full_a5");

    applyStimulus("addr_nack", 8'h5A, 1'b0, 1'b1, 1'b1);
    checkOutput("addr_nack");

    applyStimulus("data_nack", 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("data_nack");

    applyStimulus("full_ff", 8'hFF, 1'b1, 1'b1, 1'b1);
    checkOutput("full_ff");

    applyStimulus("mid_start", 8'hC3, 1'b1, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    start   = 1'b1;
    duty_in = 8'h11;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid_start");
    extra_done = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("mid_start extra_done", extra_done, 0);

    applyStimulus("reset_mid", 8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (218) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid sda_oe", sda_oe, 0);
    check("reset_mid scl_oe", scl_oe, 0);
    check("reset_mid busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus("after_reset", 8'h96, 1'b1, 1'b1, 1'b1);
    checkOutput("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
